// File: rtl/turbo_ram_arbiter_if.sv
// CPU turbo-path / chip RAM bus bundle for turbo_ram_arbiter.
// master drives requests and chipset status, slave is the arbiter.
interface turbo_ram_arbiter_if;
  logic        clk7_en;
  logic        cpu_ph2;
  logic        cpu_sel;
  logic [22:0] cpu_addr;
  logic        cpu_uds;
  logic        cpu_lds;
  logic        chip_oe_n;
  logic        chip_we_n;
  logic        refresh;
  logic [15:0] ram_din;
  logic        ram_cs;
  logic        ram_oe_n;
  logic [22:0] ram_addr;
  logic        ram_uds;
  logic        ram_lds;
  logic [15:0] cpu_dout;
  logic        cpu_ready;
  logic        cpu_fallback;
  logic [15:0] stat_grants;
  logic [15:0] stat_stalls;

  modport master (
    output clk7_en, cpu_ph2, cpu_sel,
    output cpu_addr, cpu_uds, cpu_lds,
    output chip_oe_n, chip_we_n, refresh,
    output ram_din,
    input  ram_cs, ram_oe_n, ram_addr,
    input  ram_uds, ram_lds, cpu_dout,
    input  cpu_ready, cpu_fallback,
    input  stat_grants, stat_stalls
  );

  modport slave (
    input  clk7_en, cpu_ph2, cpu_sel,
    input  cpu_addr, cpu_uds, cpu_lds,
    input  chip_oe_n, chip_we_n, refresh,
    input  ram_din,
    output ram_cs, ram_oe_n, ram_addr,
    output ram_uds, ram_lds, cpu_dout,
    output cpu_ready, cpu_fallback,
    output stat_grants, stat_stalls
  );
endinterface

// File: rtl/turbo_ram_arbiter.sv
// Slots CPU turbo RAM accesses into free clk7 slots; chipset wins.
// Optional slot statistics: define TURBO_RAM_STATS_EN.
module turbo_ram_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                clk_sys,
  input logic                reset,
  turbo_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  logic        chip_busy;
  logic        cs_q;
  logic        ready_q;
  logic        fb_q;
  logic [22:0] addr_q;
  logic        uds_q;
  logic        lds_q;
  logic [15:0] dout_q;

  assign chip_busy = ~bus.chip_oe_n
                   | ~bus.chip_we_n
                   | bus.refresh;
  assign wait_nxt  = wait_cnt + 8'd1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cs_q     <= 1'b0;
      ready_q  <= 1'b0;
      fb_q     <= 1'b0;
      addr_q   <= '0;
      uds_q    <= 1'b0;
      lds_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      fb_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cpu_ph2 && bus.cpu_sel) begin
            addr_q   <= bus.cpu_addr;
            uds_q    <= bus.cpu_uds;
            lds_q    <= bus.cpu_lds;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (!bus.cpu_sel) begin
            state <= IDLE;
          end else if (bus.clk7_en) begin
            if (chip_busy) begin
              wait_cnt <= wait_nxt;
              if (wait_nxt == WAIT_LIM) begin
                fb_q  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              cs_q  <= 1'b1;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!bus.cpu_sel) begin
            cs_q  <= 1'b0;
            state <= IDLE;
          end else if (bus.clk7_en) begin
            cs_q <= 1'b0;
            if (!chip_busy) begin
              dout_q  <= bus.ram_din;
              ready_q <= 1'b1;
              state   <= IDLE;
            end else begin
              // collision still counts toward the bounded wait
              wait_cnt <= wait_nxt;
              if (wait_nxt == WAIT_LIM) begin
                fb_q  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= REQ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_cs       = cs_q;
  assign bus.ram_oe_n     = bus.chip_oe_n & ~cs_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_uds      = uds_q;
  assign bus.ram_lds      = lds_q;
  assign bus.cpu_dout     = dout_q;
  assign bus.cpu_ready    = ready_q;
  assign bus.cpu_fallback = fb_q;

`ifdef TURBO_RAM_STATS_EN
  logic [15:0] grants_q;
  logic [15:0] stalls_q;
  logic        grant_hit;
  logic        stall_hit;

  assign grant_hit = (state == ACCESS) && bus.cpu_sel
                   && bus.clk7_en && !chip_busy;
  assign stall_hit = (state == REQ) && bus.cpu_sel
                   && bus.clk7_en && chip_busy;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (grant_hit && grants_q != 16'hFFFF)
        grants_q <= grants_q + 16'd1;
      if (stall_hit && stalls_q != 16'hFFFF)
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign bus.stat_grants = grants_q;
  assign bus.stat_stalls = stalls_q;
`else
  assign bus.stat_grants = '0;
  assign bus.stat_stalls = '0;
`endif

endmodule
